// File: rtl/guess_pkg.sv
// Shared types and display/LED constants for the guessing game engine.
package guess_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam logic [3:0]  BCD_DASH  = 4'hA;
  localparam logic [3:0]  BCD_BLANK = 4'hF;
  localparam logic [15:0] LED_WIN   = 16'hFFFF;
  localparam logic [15:0] LED_LOSE  = 16'hAAAA;

endpackage

// File: rtl/bcd_free_counter.sv
// Free-running DIGITS-wide BCD counter; +1 every clock, wraps after all-9s.
// Serves as the game's random source (sampled on a start pulse).
module bcd_free_counter #(
  parameter int DIGITS = 2
) (
  input  logic                   clk,
  input  logic                   db_rst,
  output logic [DIGITS-1:0][3:0] count
);

  // inc[g]: every digit below g is 9, so digit g steps this cycle
  logic [DIGITS-1:0] inc;

  assign inc[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    if (g > 0) begin : g_carry
      assign inc[g] = inc[g-1] & (count[g-1] == 4'd9);
    end

    // per-digit BCD increment with wrap 9 -> 0
    always_ff @(posedge clk or posedge db_rst) begin
      if (db_rst)
        count[g] <= 4'd0;
      else if (inc[g])
        count[g] <= (count[g] == 4'd9) ? 4'd0 : count[g] + 4'd1;
    end
  end

endmodule

// File: rtl/guess_game_core.sv
// Number-guessing game engine: bisection over DIGITS-wide BCD numbers with
// backspace, an attempt limit and a timed WIN/LOSE screen. Outputs are
// registered from next-state values so they reflect an event right after
// the edge that samples it.
module guess_game_core
  import guess_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int MAX_TRIES   = 7,
  parameter int HOLD_CYCLES = 512
) (
  input  logic                  clk,
  input  logic                  db_rst,
  input  logic                  start,
  input  logic                  key_valid,
  input  logic [3:0]            key_digit,
  input  logic                  key_enter,
  input  logic                  key_back,
  input  logic                  cheat,
  output logic [8*DIGITS-1:0]   disp,
  output logic [15:0]           led,
  output logic                  game_over
);

  localparam int W  = 4*DIGITS;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [W-1:0]  DASHES = {DIGITS{BCD_DASH}};
  localparam logic [W-1:0]  BLANKS = {DIGITS{BCD_BLANK}};
  localparam logic [W-1:0]  NINES  = {DIGITS{4'd9}};
  localparam logic [4:0]    TRIES_MAX = 5'(MAX_TRIES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t         state, state_n;
  logic [W-1:0]   lower, lower_n, upper, upper_n;
  logic [W-1:0]   entry, entry_n, target, target_n;
  logic [4:0]     tries, tries_n;
  logic [HW-1:0]  hold_cnt, hold_n;
  logic [W-1:0]   count;

  logic [8*DIGITS-1:0] disp_n;
  logic [15:0]         led_n;
  logic                game_over_n;
  logic                has_dash, guess_ok;
  logic [4:0]          remaining;
  logic [16:0]         thermo;

  bcd_free_counter #(.DIGITS(DIGITS)) u_rng (
    .clk    (clk),
    .db_rst (db_rst),
    .count  (count)
  );

  // entry validity: no dash digit and inside the inclusive bounds
  always_comb begin
    has_dash = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (entry[4*i +: 4] == BCD_DASH) has_dash = 1'b1;
    guess_ok = !has_dash && (entry >= lower) && (entry <= upper);
  end

  // next-state and datapath updates; enter beats back beats digit
  always_comb begin
    state_n  = state;
    lower_n  = lower;
    upper_n  = upper;
    entry_n  = entry;
    target_n = target;
    tries_n  = tries;
    hold_n   = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_ENTRY;
          lower_n  = '0;
          upper_n  = NINES;
          tries_n  = '0;
          entry_n  = DASHES;
          target_n = count;
        end
      end
      ST_ENTRY: begin
        hold_n = '0;
        if (key_enter) begin
          entry_n = DASHES;
          if (guess_ok) begin
            if (entry == target) begin
              state_n = ST_WIN;
            end else begin
              tries_n = tries + 5'd1;
              if (entry > target) upper_n = entry;
              else                lower_n = entry;
              if (tries + 5'd1 == TRIES_MAX) state_n = ST_LOSE;
            end
          end
        end else if (key_back) begin
          entry_n = W'({BCD_DASH, entry} >> 4);
        end else if (key_valid && key_digit <= 4'd9) begin
          entry_n = W'({entry, key_digit});
        end
      end
      ST_WIN, ST_LOSE: begin
        if (hold_cnt == HOLD_LAST) begin
          state_n = ST_IDLE;
          hold_n  = '0;
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // output image computed from the next state so it lands with the event
  always_comb begin
    remaining   = TRIES_MAX - tries_n;
    thermo      = (17'd1 << remaining) - 17'd1;
    disp_n      = {DASHES, DASHES};
    led_n       = '0;
    game_over_n = (state == ST_ENTRY) && (state_n == ST_WIN || state_n == ST_LOSE);
    case (state_n)
      ST_ENTRY: begin
        if (cheat)                disp_n = {target_n, BLANKS};
        else if (entry_n != DASHES) disp_n = {BLANKS, entry_n};
        else                      disp_n = {lower_n, upper_n};
        led_n = thermo[15:0];
      end
      ST_WIN: begin
        disp_n = {target_n, target_n};
        led_n  = LED_WIN;
      end
      ST_LOSE: begin
        disp_n = {target_n, DASHES};
        led_n  = LED_LOSE;
      end
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge db_rst) begin
    if (db_rst) state <= ST_IDLE;
    else        state <= state_n;
  end

  // datapath and registered outputs
  always_ff @(posedge clk or posedge db_rst) begin
    if (db_rst) begin
      lower     <= '0;
      upper     <= NINES;
      entry     <= DASHES;
      target    <= '0;
      tries     <= '0;
      hold_cnt  <= '0;
      disp      <= {DASHES, DASHES};
      led       <= '0;
      game_over <= 1'b0;
    end else begin
      lower     <= lower_n;
      upper     <= upper_n;
      entry     <= entry_n;
      target    <= target_n;
      tries     <= tries_n;
      hold_cnt  <= hold_n;
      disp      <= disp_n;
      led       <= led_n;
      game_over <= game_over_n;
    end
  end

endmodule

// File: doc/guess_game_core.md
# guess_game_core

Parametrised number-guessing game engine. It takes already-decoded keypad events and produces a packed-BCD display image plus an LED status word.

- Generalises the fixed 2-digit bisection game to `DIGITS`-wide numbers.
- Adds backspace, an attempt limit with a lose condition, and a configurable result-hold time.
- Sits between the PS/2 key decoder / one-pulse stage and the multiplexed seven-segment driver.

## Interface
- `DIGITS`, 2, number of BCD digits per number (1–4).
- `MAX_TRIES`, 7, valid guesses allowed per game (1–16).
- `HOLD_CYCLES`, 512, cycles the WIN/LOSE screen is held before returning to IDLE.

- `clk`  in  1  clock; all inputs sampled on rising edge.
- `db_rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a game (honoured in IDLE only).
- `key_valid`  in  1  one-cycle pulse; `key_digit` holds a new digit 0–9.
- `key_digit`  in  4  digit value; values above 9 are ignored.
- `key_enter`  in  1  one-cycle pulse; submit the entry.
- `key_back`  in  1  one-cycle pulse; delete the last digit.
- `cheat`  in  1  level; show the target while high (ENTRY only).
- `disp`  out  8*DIGITS  display image {left field, right field}, each 4*DIGITS packed BCD.
- `led`  out  16  status LEDs.
- `game_over`  out  1  one-cycle pulse on entry to WIN or LOSE.

## Operation
Display codes:
- 4'hA shows a dash; 4'hF is blank.
- "All-9s" means every digit 9; "dashes" means every digit 4'hA.

Random source:
- Free-running BCD counter, 0 in reset.
- +1 every clk, wrapping after all-9s to 0.
- On a honoured `start`, `target` ← counter value before that edge.

States:
- IDLE
  - disp = dashes|dashes, led = 0.
  - `start` → ENTRY: lower = 0, upper = all-9s, tries = 0, entry = dashes, target captured.
- ENTRY, per-event priority enter > back > digit (lower-priority events in the same cycle are dropped).
  - digit: entry shifts left one digit, new digit in the LSD, MSD discarded.
  - back: entry shifts right one digit, dash into the MSD. No effect if entry is already dashes.
  - enter with entry containing any dash, or entry < lower, or entry > upper (packed-BCD unsigned compare): invalid. tries unchanged, entry cleared to dashes.
  - enter, valid and equal to target → WIN.
  - enter, valid and > target: upper = entry, tries+1, entry cleared.
  - enter, valid and < target: lower = entry, tries+1, entry cleared.
  - If tries+1 == MAX_TRIES and the guess missed → LOSE instead of staying in ENTRY.
  - disp priority: cheat → target|blank; entry not all dashes → blank|entry; else lower|upper.
  - led[MAX_TRIES-1:0] = thermometer of remaining tries (MAX_TRIES − tries ones from bit 0), other bits 0.
- WIN: disp = target|target, led = 16'hFFFF.
- LOSE: disp = target|dashes, led = 16'hAAAA.
- WIN/LOSE exit: hold counter reset on entry; return to IDLE after exactly HOLD_CYCLES cycles.
- `start` outside IDLE is ignored; `cheat` outside ENTRY is ignored.

## Timing
- `disp`, `led` and `game_over` are registered. Each reflects an input event one cycle after the sampling edge.
- Reset values: state IDLE, disp = dashes|dashes, led = 0, game_over = 0, counter/target/tries/lower = 0, upper = all-9s, entry = dashes.
- Reset mid-game aborts immediately to these values; no event is lost or replayed after release.
- `game_over` is high for exactly the first cycle of WIN/LOSE.
- The final guess of a game is judged first: a correct final guess gives WIN, not LOSE.
- The guess exactly equal to lower or upper is valid (bounds inclusive).

## Structure
- Package `guess_pkg`:
  - state enum (IDLE, ENTRY, WIN, LOSE);
  - `BCD_DASH` = 4'hA, `BCD_BLANK` = 4'hF;
  - `LED_WIN` = 16'hFFFF, `LED_LOSE` = 16'hAAAA.
- One sub-module `bcd_free_counter #(DIGITS)` as the random source: ripple-carry BCD increment, wrap at all-9s.
- Remaining logic is one FSM with registered outputs.

## Test plan
Bench parameters: DIGITS=2, MAX_TRIES=3, HOLD_CYCLES=4.
1. Reset release, `start` on the 38th edge → target=37. disp=00|99, led[2:0]=111, led[15:3]=0.
2. Target 37, enter 50 then 20 → disp 00|50 then 20|50; led 011 then 001. Enter 37 → disp 37|37, led FFFF, game_over one cycle; IDLE after 4 cycles.
3. Target 37, three misses 50, 20, 40 → LOSE: disp 37|AA, led AAAA; IDLE after 4 cycles.
4. Bounds 20|50, enter 60 → invalid, tries unchanged. Enter with one digit only ("A5") → invalid, display returns to 20|50.
5. Type 4, 5, back, 6 → entry 46. key_enter and key_valid in the same cycle → the digit is dropped.
6. `cheat` high in ENTRY → disp 37|FF; `cheat` in IDLE → dashes. `db_rst` pulsed during ENTRY → all reset values on the next sample.
